selector41_reg: RTL and testbench
=================================

Name: selector41_reg

Overview:
- Parameterised 4-to-1 word selector.
- Two select bits {iS1,iS0} choose one of four data words iC0..iC3.
- The chosen word is driven on a combinational output. A registered copy and registered status are also produced for downstream synchronous logic.
- Sits in datapath glue wherever one of four same-width sources must be steered to a single consumer.

Parameters:
- WIDTH, 4, bit width of each data input and of the data outputs (legal range 1..64).

Ports:
- iClk  input  1  system clock; all registers update on the rising edge.
- iRst_n  input  1  synchronous, active-low reset, sampled on the rising edge of iClk.
- iS1  input  1  select bit, most significant.
- iS0  input  1  select bit, least significant.
- iC0  input  WIDTH  data word, chosen when {iS1,iS0}=00.
- iC1  input  WIDTH  data word, chosen when {iS1,iS0}=01.
- iC2  input  WIDTH  data word, chosen when {iS1,iS0}=10.
- iC3  input  WIDTH  data word, chosen when {iS1,iS0}=11.
- oZ  output  WIDTH  combinational selected word; zero latency.
- oZ_q  output  WIDTH  registered selected word; one-cycle latency.
- oSel_q  output  2  registered select code {iS1,iS0}.
- oChg  output  1  one-cycle pulse: the registered select code changed on this edge.

Behaviour:
- Combinational path:
  - oZ = iC0 / iC1 / iC2 / iC3 for {iS1,iS0} = 00 / 01 / 10 / 11.
  - Purely combinational; follows any change on select or data within the same delta, independent of clock and reset.
  - Reset does not force oZ.
- Unknown select: if either select bit is X/Z in simulation, oZ is all zeros. No X is propagated from select; data X still propagates.
- Registered path, on each rising iClk:
  - iRst_n=0 → oZ_q = 0, oSel_q = 2'b00, oChg = 0.
  - iRst_n=1 → oZ_q ← oZ, oSel_q ← {iS1,iS0}, oChg ← ({iS1,iS0} != oSel_q).
- Reset mid-operation:
  - Registered outputs clear on the next edge.
  - The first post-reset edge compares against 2'b00, so oChg rises only if select is non-zero.
- Simultaneous select and data change: the registered output captures the new word from the new channel in the same edge. No glitch filtering.
- Data words are passed bit-exact. No arithmetic, no sign handling, no width conversion.
- No handshake; every cycle is valid.

Decomposition:
- Shared package: localparams SEL_C0=2'b00, SEL_C1=2'b01, SEL_C2=2'b10, SEL_C3=2'b11; a 2-bit select typedef.
- One natural sub-module: selector41_comb. It is the pure combinational WIDTH-parameterised 4:1 mux and supplies oZ.
- The top wraps selector41_comb with the output/select registers and the change detector.

Test Plan:
- Reset and zero data: iRst_n=0, select 00, all iC=0000, one edge. Then oZ=0000, oZ_q=0000, oSel_q=00, oChg=0.
- Channel 0 isolation: select 00; iC0..iC3 = 1111/0111/0011/0001, then iC0=1111 others 0000, then iC0=0011 others 0000. oZ = 1111, 1111, 0011 immediately; oZ_q matches one edge later.
- Channel 1 isolation: select 01 with data 1111/0111/0011/0001 → oZ=0111. Then iC1=0111 others 0 → 0111. Then iC1=1111 others 0 → 1111. oChg=1 for exactly one cycle after the 00→01 change.
- Channel 2 isolation: select 10 with data 1111/0111/0011/0001 → oZ=0011. Then iC2=0011 → 0011. Then iC2=1111 → 1111. Non-selected inputs toggling has no effect on oZ.
- Channel 3 isolation: select 11 with data 1111/0111/0011/0001 → oZ=0001. Then iC3=0001 → 0001. Then iC3=1111 → 1111. oSel_q=11 one edge later.
- Reset mid-stream:
  - Select 11, iC3=1111; assert iRst_n=0 for one edge. Then oZ_q=0000, oSel_q=00, while oZ stays 1111.
  - Release reset. Next edge gives oZ_q=1111, oSel_q=11, oChg=1.

Source files
------------

// File: rtl/selector41_reg_pkg.sv
// Shared select-code definitions for the 4:1 word selector.
package selector41_reg_pkg;

    localparam int unsigned SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t SEL_C0 = 2'b00;
    localparam sel_t SEL_C1 = 2'b01;
    localparam sel_t SEL_C2 = 2'b10;
    localparam sel_t SEL_C3 = 2'b11;

endpackage

// File: rtl/selector41_comb.sv
// Pure combinational WIDTH-bit 4:1 mux; an unknown select yields all zeros.
module selector41_comb
    import selector41_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  sel_t             sel_i,
    input  logic [WIDTH-1:0] c0_i,
    input  logic [WIDTH-1:0] c1_i,
    input  logic [WIDTH-1:0] c2_i,
    input  logic [WIDTH-1:0] c3_i,
    output logic [WIDTH-1:0] z_o
);

    // X/Z on select matches no item, so the default keeps X off the output
    always_comb begin
        z_o = '0;
        case (sel_i)
            SEL_C0:  z_o = c0_i;
            SEL_C1:  z_o = c1_i;
            SEL_C2:  z_o = c2_i;
            SEL_C3:  z_o = c3_i;
            default: z_o = '0;
        endcase
    end

endmodule

// File: rtl/selector41_reg.sv
// 4:1 word selector with combinational output, registered copy, registered
// select code and a select-change pulse.
module selector41_reg
    import selector41_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iS1,
    input  logic             iS0,
    input  logic [WIDTH-1:0] iC0,
    input  logic [WIDTH-1:0] iC1,
    input  logic [WIDTH-1:0] iC2,
    input  logic [WIDTH-1:0] iC3,
    output logic [WIDTH-1:0] oZ,
    output logic [WIDTH-1:0] oZ_q,
    output logic [1:0]       oSel_q,
    output logic             oChg
);

    sel_t             sel;
    logic [WIDTH-1:0] z_d;
    logic [WIDTH-1:0] z_q;
    sel_t             sel_d;
    sel_t             sel_q;
    logic             chg_d;
    logic             chg_q;

    assign sel = {iS1, iS0};

    selector41_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .sel_i (sel),
        .c0_i  (iC0),
        .c1_i  (iC1),
        .c2_i  (iC2),
        .c3_i  (iC3),
        .z_o   (oZ)
    );

    // Next-state: capture the selected word, the code, and whether it moved
    always_comb begin
        z_d   = oZ;
        sel_d = sel;
        chg_d = (sel != sel_q);
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            z_q   <= '0;
            sel_q <= SEL_C0;
            chg_q <= 1'b0;
        end else begin
            z_q   <= z_d;
            sel_q <= sel_d;
            chg_q <= chg_d;
        end
    end

    assign oZ_q   = z_q;
    assign oSel_q = sel_q;
    assign oChg   = chg_q;

endmodule

// File: tb/tb_selector41_reg.sv
// Directed self-checking bench for selector41_reg (WIDTH = 4).
module tb_selector41_reg;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             s1;
    logic             s0;
    logic [WIDTH-1:0] c0;
    logic [WIDTH-1:0] c1;
    logic [WIDTH-1:0] c2;
    logic [WIDTH-1:0] c3;
    logic [WIDTH-1:0] z;
    logic [WIDTH-1:0] z_q;
    logic [1:0]       sel_q;
    logic             chg;

    int n_cmp = 0;
    int n_bad = 0;

    selector41_reg #(
        .WIDTH (WIDTH)
    ) dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .iS1    (s1),
        .iS0    (s0),
        .iC0    (c0),
        .iC1    (c1),
        .iC2    (c2),
        .iC3    (c3),
        .oZ     (z),
        .oZ_q   (z_q),
        .oSel_q (sel_q),
        .oChg   (chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] sel, input logic [3:0] d0, input logic [3:0] d1,
                         input logic [3:0] d2, input logic [3:0] d3);
        {s1, s0} = sel;
        c0 = d0;
        c1 = d1;
        c2 = d2;
        c3 = d3;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(2'b00, 4'h0, 4'h0, 4'h0, 4'h0);

        // Reset with zero data
        tick();
        check("rst_z",     64'(z),     64'h0);
        check("rst_z_q",   64'(z_q),   64'h0);
        check("rst_sel_q", 64'(sel_q), 64'h0);
        check("rst_chg",   64'(chg),   64'h0);
        rst_n = 1'b1;

        // Channel 0
        drive(2'b00, 4'hF, 4'h7, 4'h3, 4'h1);
        check("c0_a_z", 64'(z), 64'hF);
        tick();
        check("c0_a_z_q", 64'(z_q),   64'hF);
        check("c0_a_sel", 64'(sel_q), 64'h0);
        check("c0_a_chg", 64'(chg),   64'h0);
        drive(2'b00, 4'hF, 4'h0, 4'h0, 4'h0);
        check("c0_b_z", 64'(z), 64'hF);
        tick();
        check("c0_b_z_q", 64'(z_q), 64'hF);
        drive(2'b00, 4'h3, 4'h0, 4'h0, 4'h0);
        check("c0_c_z", 64'(z), 64'h3);
        tick();
        check("c0_c_z_q", 64'(z_q), 64'h3);

        // Channel 1: 00 -> 01 gives a single-cycle change pulse
        drive(2'b01, 4'hF, 4'h7, 4'h3, 4'h1);
        check("c1_a_z", 64'(z), 64'h7);
        tick();
        check("c1_a_z_q", 64'(z_q),   64'h7);
        check("c1_a_sel", 64'(sel_q), 64'h1);
        check("c1_a_chg", 64'(chg),   64'h1);
        drive(2'b01, 4'h0, 4'h7, 4'h0, 4'h0);
        check("c1_b_z", 64'(z), 64'h7);
        tick();
        check("c1_b_z_q", 64'(z_q), 64'h7);
        check("c1_b_chg", 64'(chg), 64'h0);
        drive(2'b01, 4'h0, 4'hF, 4'h0, 4'h0);
        check("c1_c_z", 64'(z), 64'hF);
        tick();
        check("c1_c_z_q", 64'(z_q), 64'hF);

        // Channel 2, with unselected inputs toggling
        drive(2'b10, 4'hF, 4'h7, 4'h3, 4'h1);
        check("c2_a_z", 64'(z), 64'h3);
        tick();
        check("c2_a_z_q", 64'(z_q),   64'h3);
        check("c2_a_sel", 64'(sel_q), 64'h2);
        check("c2_a_chg", 64'(chg),   64'h1);
        drive(2'b10, 4'h0, 4'h0, 4'h3, 4'h0);
        check("c2_b_z", 64'(z), 64'h3);
        drive(2'b10, 4'hF, 4'hA, 4'h3, 4'h5);
        check("c2_tog_z", 64'(z), 64'h3);
        tick();
        check("c2_b_chg", 64'(chg), 64'h0);
        drive(2'b10, 4'h0, 4'h0, 4'hF, 4'h0);
        check("c2_c_z", 64'(z), 64'hF);
        tick();
        check("c2_c_z_q", 64'(z_q), 64'hF);

        // Channel 3
        drive(2'b11, 4'hF, 4'h7, 4'h3, 4'h1);
        check("c3_a_z", 64'(z), 64'h1);
        tick();
        check("c3_a_z_q", 64'(z_q),   64'h1);
        check("c3_a_sel", 64'(sel_q), 64'h3);
        check("c3_a_chg", 64'(chg),   64'h1);
        drive(2'b11, 4'h0, 4'h0, 4'h0, 4'h1);
        check("c3_b_z", 64'(z), 64'h1);
        tick();
        check("c3_b_z_q", 64'(z_q), 64'h1);
        drive(2'b11, 4'h0, 4'h0, 4'h0, 4'hF);
        check("c3_c_z", 64'(z), 64'hF);
        tick();
        check("c3_c_z_q", 64'(z_q),   64'hF);
        check("c3_c_sel", 64'(sel_q), 64'h3);
        check("c3_c_chg", 64'(chg),   64'h0);

        // Reset mid-stream: registers clear, combinational output holds
        rst_n = 1'b0;
        tick();
        check("mrst_z",     64'(z),     64'hF);
        check("mrst_z_q",   64'(z_q),   64'h0);
        check("mrst_sel_q", 64'(sel_q), 64'h0);
        check("mrst_chg",   64'(chg),   64'h0);
        rst_n = 1'b1;
        tick();
        check("post_z_q",   64'(z_q),   64'hF);
        check("post_sel_q", 64'(sel_q), 64'h3);
        check("post_chg",   64'(chg),   64'h1);
        tick();
        check("post2_chg",  64'(chg),   64'h0);

        // Select and data change together: new word from new channel
        drive(2'b01, 4'h0, 4'h9, 4'h0, 4'h6);
        tick();
        check("sim_z_q", 64'(z_q),   64'h9);
        check("sim_sel", 64'(sel_q), 64'h1);
        check("sim_chg", 64'(chg),   64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
